// File: rtl/dm_pkg.sv
// dm_pkg: shared types and helpers for the data-memory responder.
// Trace entry layout, byte-enable constants, lane mask helper.
package dm_pkg;

  localparam int TRACE_W  = 100;
  localparam int BE_LSB   = 0;
  localparam int DATA_LSB = 4;
  localparam int ADDR_LSB = 36;
  localparam int PC_LSB   = 68;

  localparam logic [3:0] BYTEEN_NONE    = 4'b0000;
  localparam logic [3:0] BYTEEN_WORD    = 4'b1111;
  localparam logic [3:0] BYTEEN_HALF_LO = 4'b0011;
  localparam logic [3:0] BYTEEN_HALF_HI = 4'b1100;

  function automatic logic [31:0] byteen_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// trace_fifo: synchronous FIFO holding write-trace entries.
// Ports: clk/reset (async, active-low); push/push_data; pop;
//   full/empty status; head data; overflow pulse when a push is dropped.
module trace_fifo #(
  parameter int W     = 100,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic         overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

  assign do_pop  = pop && !empty;
  // a pop on the same edge frees the slot a full push needs
  assign do_push = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;

  assign head = store[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory-side end of the CPU m_data_* interface.
// Ports: clk, reset (async, active-low); m_data_addr/wdata/byteen,
//   m_inst_addr in; m_data_rdata out; trace_valid/ready handshake with
//   trace_pc/addr/data/byteen head; sticky trace_overflow, addr_err.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_byteen,
  output logic        trace_overflow,
  output logic        addr_err
);

  localparam int WORDS = 2 ** ADDR_WIDTH;

  logic [31:0] mem [WORDS] = '{default: '0};

  logic [29:0]           woff;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic [31:0]           old_word;
  logic [31:0]           mask;
  logic [31:0]           merged;
  logic                  we;
  logic [TRACE_W-1:0]    push_data;
  logic [TRACE_W-1:0]    head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_ovf;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^m_data_addr[1:0];

  // word offset from base; anything below base wraps high and fails
  assign woff = m_data_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = ((woff >> ADDR_WIDTH) == '0);
  assign idx = woff[ADDR_WIDTH-1:0];

  assign old_word = mem[idx];
  assign mask     = byteen_mask(m_data_byteen);
  assign merged   = (old_word & ~mask) |
                    (m_data_wdata & mask);

  assign m_data_rdata = in_range ? old_word : '0;

  assign we = reset && in_range &&
              (m_data_byteen != BYTEEN_NONE);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= merged;
    end
  end

  always_comb begin
    push_data = '0;
    push_data[PC_LSB   +: 32] = m_inst_addr;
    push_data[ADDR_LSB +: 32] = {m_data_addr[31:2], 2'b00};
    push_data[DATA_LSB +: 32] = merged;
    push_data[BE_LSB   +: 4]  = m_data_byteen;
  end

  trace_fifo #(
    .W     (TRACE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (we),
    .push_data (push_data),
    .pop       (trace_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .overflow  (fifo_ovf)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  assign trace_valid  = !fifo_empty;
  assign trace_pc     = trace_valid ? head[PC_LSB +: 32]   : '0;
  assign trace_addr   = trace_valid ? head[ADDR_LSB +: 32] : '0;
  assign trace_data   = trace_valid ? head[DATA_LSB +: 32] : '0;
  assign trace_byteen = trace_valid ? head[BE_LSB +: 4]    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_overflow <= 1'b0;
      addr_err       <= 1'b0;
    end else begin
      if (fifo_ovf) begin
        trace_overflow <= 1'b1;
      end
      if (!in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized bench for dm_responder.
// Checks every cycle against a queue/array reference model.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 8;
  localparam int          WORDS = 2 ** AW;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  trace_byteen;
  logic        trace_overflow;
  logic        addr_err;

  dm_responder #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m_data_addr    (m_data_addr),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_inst_addr    (m_inst_addr),
    .m_data_rdata   (m_data_rdata),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_byteen   (trace_byteen),
    .trace_overflow (trace_overflow),
    .addr_err       (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic [31:0] mdl_mem [WORDS];
  ent_t        mdl_q [$];
  bit          mdl_ovf;
  bit          mdl_err;

  int n_chk;
  int n_pass;

  task automatic check(input string tag,
                       input logic [99:0] got,
                       input logic [99:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic bit mdl_in(input logic [31:0] a);
    longint unsigned la, lb;
    la = a;
    lb = BASE;
    return (la >= lb) && (la < lb + 4 * WORDS);
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic check_outputs();
    ent_t e;
    logic [31:0] er;
    er = mdl_in(m_data_addr) ?
         mdl_mem[mdl_idx(m_data_addr)] : 32'h0;
    check("rdata", m_data_rdata, er);
    check("valid", trace_valid, mdl_q.size() > 0);
    if (mdl_q.size() > 0) e = mdl_q[0];
    else e = '{pc: 0, addr: 0, data: 0, be: 0};
    check("t_pc", trace_pc, e.pc);
    check("t_addr", trace_addr, e.addr);
    check("t_data", trace_data, e.data);
    check("t_be", trace_byteen, e.be);
    check("ovf", trace_overflow, mdl_ovf);
    check("aerr", addr_err, mdl_err);
  endtask

  task automatic mdl_step();
    bit in_r, pop, full;
    logic [31:0] old, nw;
    ent_t e;
    in_r = mdl_in(m_data_addr);
    if (!in_r) mdl_err = 1;
    pop  = trace_ready && (mdl_q.size() > 0);
    full = (mdl_q.size() == DEPTH) && !pop;
    if (pop) void'(mdl_q.pop_front());
    if (in_r && m_data_byteen != 4'h0) begin
      old = mdl_mem[mdl_idx(m_data_addr)];
      for (int i = 0; i < 4; i++)
        nw[8*i +: 8] = m_data_byteen[i] ?
          m_data_wdata[8*i +: 8] : old[8*i +: 8];
      mdl_mem[mdl_idx(m_data_addr)] = nw;
      e.pc   = m_inst_addr;
      e.addr = {m_data_addr[31:2], 2'b00};
      e.data = nw;
      e.be   = m_data_byteen;
      if (full) mdl_ovf = 1;
      else mdl_q.push_back(e);
    end
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [3:0]  be,
                       input logic [31:0] pc,
                       input logic        rdy);
    @(negedge clk);
    m_data_addr   = a;
    m_data_wdata  = wd;
    m_data_byteen = be;
    m_inst_addr   = pc;
    trace_ready   = rdy;
    #1;
    check_outputs();
  endtask

  task automatic commit();
    @(posedge clk);
    mdl_step();
  endtask

  task automatic cycle(input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [3:0]  be,
                       input logic [31:0] pc,
                       input logic        rdy);
    drive(a, wd, be, pc, rdy);
    commit();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (mdl_q.size() > 0 && g < 40) begin
      cycle(BASE, 32'h0, BYTEEN_NONE, 32'h0, 1'b1);
      g++;
    end
  endtask

  task automatic rand_cycles(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = BASE + ($urandom_range(0, 31) << 2)
               + $urandom_range(0, 3);
      cycle(a, $urandom, 4'($urandom),
            $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  logic [31:0] d9;
  logic [31:0] held;

  initial begin
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < WORDS; i++) mdl_mem[i] = '0;
    mdl_ovf = 0;
    mdl_err = 0;
    reset = 1'b0;
    m_data_addr = BASE;
    m_data_wdata = '0;
    m_data_byteen = '0;
    m_inst_addr = '0;
    trace_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // word store then byte store merge
    cycle(BASE + 32'h10, 32'h1122_3344, BYTEEN_WORD,
          32'h100, 1'b0);
    cycle(BASE + 32'h10, 32'h00AA_0000, 4'b0100,
          32'h104, 1'b0);
    drive(BASE + 32'h10, 32'h0, BYTEEN_NONE, 32'h0, 1'b1);
    check("merge_rd", m_data_rdata, 32'h11AA_3344);
    check("tr0_data", trace_data, 32'h1122_3344);
    check("tr0_be", trace_byteen, 4'hF);
    commit();
    drive(BASE + 32'h10, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    check("tr1_data", trace_data, 32'h11AA_3344);
    check("tr1_be", trace_byteen, 4'h4);
    check("tr1_addr", trace_addr, BASE + 32'h10);
    commit();

    // read during write
    drive(BASE + 32'h20, 32'hDEAD_BEEF, BYTEEN_WORD,
          32'h200, 1'b0);
    check("rdw_old", m_data_rdata, 32'h0);
    commit();
    drive(BASE + 32'h20, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    check("rdw_new", m_data_rdata, 32'hDEAD_BEEF);
    commit();
    drain();

    // fill past depth with ready low
    d9 = 32'h0;
    for (int i = 0; i < 9; i++) begin
      d9 = $urandom;
      cycle(BASE + 32'h100 + 32'(4 * i), d9, BYTEEN_WORD,
            32'h1000 + 32'(4 * i), 1'b0);
    end
    drive(BASE + 32'h120, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    check("ovf_set", trace_overflow, 1'b1);
    check("w9_mem", m_data_rdata, d9);
    check("full_head", trace_addr, BASE + 32'h100);
    commit();

    // full FIFO push with simultaneous pop
    cycle(BASE + 32'h200, 32'hCAFE_F00D, BYTEEN_HALF_HI,
          32'h2000, 1'b1);
    drain();

    // out-of-range write
    drive(BASE + 32'h4000, 32'h5555_AAAA, BYTEEN_WORD,
          32'h3000, 1'b0);
    check("oor_rd", m_data_rdata, 32'h0);
    commit();
    drive(BASE, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    check("aerr_set", addr_err, 1'b1);
    check("oor_nopush", trace_valid, 1'b0);
    commit();

    rand_cycles(300);
    drain();

    // reset with three entries queued
    cycle(BASE + 32'h40, 32'h0102_0304, BYTEEN_WORD,
          32'h400, 1'b0);
    cycle(BASE + 32'h44, 32'h0506_0708, BYTEEN_HALF_LO,
          32'h404, 1'b0);
    cycle(BASE + 32'h48, 32'h090A_0B0C, BYTEEN_WORD,
          32'h408, 1'b0);
    held = mdl_mem[mdl_idx(BASE + 32'h48)];
    @(negedge clk);
    reset = 1'b0;
    m_data_byteen = BYTEEN_NONE;
    #1;
    check("rst_valid", trace_valid, 1'b0);
    check("rst_ovf", trace_overflow, 1'b0);
    check("rst_aerr", addr_err, 1'b0);
    check("rst_pc", trace_pc, 32'h0);
    mdl_q.delete();
    mdl_ovf = 0;
    mdl_err = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(BASE + 32'h48, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    check("mem_kept", m_data_rdata, held);
    commit();

    rand_cycles(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
